// File: rtl/cmerge3_cache_sync_pkg.sv
// Shared definitions for the 3-to-1 drive merger: FSM states, arbitration modes,
// and the round-robin pointer advance rule.
package cmerge3_cache_sync_pkg;

   localparam int N_IN  = 3;
   localparam int SEL_W = 2;

   localparam bit PRIO_RR    = 1'b1;
   localparam bit PRIO_FIXED = 1'b0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [SEL_W-1:0] ptr_after(input logic [SEL_W-1:0] w);
      return (w == 2'd2) ? 2'd0 : w + 2'd1;
   endfunction

endpackage

// File: rtl/cmerge3_cache_sync_rr_arb3.sv
// Combinational 3-input arbiter: round-robin starting at i_ptr, or fixed priority
// with source 0 highest.
module rr_arb3
   import cmerge3_cache_sync_pkg::*;
(
   input  logic [N_IN-1:0]  i_req,
   input  logic [SEL_W-1:0] i_ptr,
   input  logic             i_mode,
   output logic [N_IN-1:0]  o_gnt,
   output logic [SEL_W-1:0] o_gnt_idx
);

   logic [SEL_W-1:0] w_start;
   logic [SEL_W:0]   w_sum;
   logic [SEL_W-1:0] w_idx;
   logic             w_found;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      o_gnt     = '0;
      o_gnt_idx = '0;
      w_found   = 1'b0;
      w_sum     = '0;
      w_idx     = '0;
      w_start   = (i_mode == PRIO_RR && i_ptr != 2'd3) ? i_ptr : 2'd0;
      for (int i = 0; i < N_IN; i++) begin
         w_sum = {1'b0, w_start} + 3'(i);
         w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[SEL_W-1:0];
         if (!w_found && i_req[w_idx]) begin
            w_found        = 1'b1;
            o_gnt[w_idx]   = 1'b1;
            o_gnt_idx      = w_idx;
         end
      end
   end

endmodule

// File: rtl/cmerge3_cache_sync.sv
// 3-to-1 drive merger: latches upstream drive pulses, grants one token at a time to
// the shared downstream stage, and returns a free pulse to the granted source.
module cmerge3_cache_sync
   import cmerge3_cache_sync_pkg::*;
#(
   parameter bit PRIO_MODE = PRIO_RR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_drive0,
   input  logic             i_drive1,
   input  logic             i_drive2,
   input  logic             i_freeNext,
   output logic             o_free0,
   output logic             o_free1,
   output logic             o_free2,
   output logic             o_driveNext,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_fire,
   output logic             o_busy,
   output logic             o_err
);

   state_t           r_state;
   state_t           w_state_next;
   logic [N_IN-1:0]  r_pending;
   logic [N_IN-1:0]  w_pending_next;
   logic [N_IN-1:0]  r_free;
   logic [SEL_W-1:0] r_rr_ptr;
   logic [SEL_W-1:0] r_sel;
   logic             r_drive_next;
   logic             r_err;

   logic [N_IN-1:0]  w_drive;
   logic [N_IN-1:0]  w_req;
   logic [N_IN-1:0]  w_gnt;
   logic [N_IN-1:0]  w_won;
   logic [SEL_W-1:0] w_gnt_idx;
   logic             w_grant;
   logic             w_busy;
   logic             w_err_now;

   assign w_drive = {i_drive2, i_drive1, i_drive0};
   // A drive arriving this cycle competes alongside already-latched tokens.
   assign w_req   = r_pending | w_drive;
   assign w_won   = {N_IN{w_grant}} & w_gnt;

   rr_arb3 u_arb (
      .i_req     (w_req),
      .i_ptr     (r_rr_ptr),
      .i_mode    (PRIO_MODE),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   // NOTE: reset is sampled on the clock edge; state uses non-blocking assignment only.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (|w_req)     w_state_next = ST_BUSY;
         ST_BUSY: if (i_freeNext) w_state_next = ST_IDLE;
         default:                 w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_grant = 1'b0;
      w_busy  = 1'b0;
      case (r_state)
         ST_IDLE: w_grant = |w_req;
         ST_BUSY: w_busy  = 1'b1;
         default: w_grant = 1'b0;
      endcase
   end

   // A granted source that drives again on the grant edge keeps the new token pending.
   always_comb begin
      w_pending_next = '0;
      w_err_now      = (r_state == ST_IDLE) && i_freeNext;
      for (int k = 0; k < N_IN; k++) begin
         w_pending_next[k] = w_won[k] ? (r_pending[k] & w_drive[k])
                                      : (r_pending[k] | w_drive[k]);
         if (w_drive[k] && r_pending[k] && !w_won[k]) w_err_now = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending    <= '0;
         r_free       <= '0;
         r_rr_ptr     <= '0;
         r_sel        <= '0;
         r_drive_next <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_pending    <= w_pending_next;
         r_free       <= w_won;
         r_drive_next <= w_grant;
         r_err        <= r_err | w_err_now;
         if (w_grant) begin
            r_sel <= w_gnt_idx;
            if (PRIO_MODE == PRIO_RR) r_rr_ptr <= ptr_after(w_gnt_idx);
         end
      end
   end

   assign o_free0     = r_free[0];
   assign o_free1     = r_free[1];
   assign o_free2     = r_free[2];
   assign o_driveNext = r_drive_next;
   assign o_fire      = r_drive_next;
   assign o_sel       = r_sel;
   assign o_busy      = w_busy;
   assign o_err       = r_err;

endmodule

// File: tb/tb_cmerge3_cache_sync.sv
// Bench for cmerge3_cache_sync: directed vector table, starvation sequence, and
// randomized traffic on a round-robin and a fixed-priority instance against a reference model.
module tb_cmerge3_cache_sync;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_drive0, i_drive1, i_drive2, i_freeNext;

   logic       rr_free0, rr_free1, rr_free2, rr_dn, rr_fire, rr_busy, rr_err;
   logic [1:0] rr_sel;
   logic       fx_free0, fx_free1, fx_free2, fx_dn, fx_fire, fx_busy, fx_err;
   logic [1:0] fx_sel;

   always #5 clk = ~clk;

   cmerge3_cache_sync #(.PRIO_MODE(1'b1)) dut_rr (
      .clk(clk), .rst(rst),
      .i_drive0(i_drive0), .i_drive1(i_drive1), .i_drive2(i_drive2), .i_freeNext(i_freeNext),
      .o_free0(rr_free0), .o_free1(rr_free1), .o_free2(rr_free2),
      .o_driveNext(rr_dn), .o_sel(rr_sel), .o_fire(rr_fire), .o_busy(rr_busy), .o_err(rr_err)
   );

   cmerge3_cache_sync #(.PRIO_MODE(1'b0)) dut_fx (
      .clk(clk), .rst(rst),
      .i_drive0(i_drive0), .i_drive1(i_drive1), .i_drive2(i_drive2), .i_freeNext(i_freeNext),
      .o_free0(fx_free0), .o_free1(fx_free1), .o_free2(fx_free2),
      .o_driveNext(fx_dn), .o_sel(fx_sel), .o_fire(fx_fire), .o_busy(fx_busy), .o_err(fx_err)
   );

   // Packed view: {driveNext, fire, free[2:0], sel[1:0], busy, err}
   logic [8:0] out_rr, out_fx;
   assign out_rr = {rr_dn, rr_fire, rr_free2, rr_free1, rr_free0, rr_sel, rr_busy, rr_err};
   assign out_fx = {fx_dn, fx_fire, fx_free2, fx_free1, fx_free0, fx_sel, fx_busy, fx_err};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model, index 0 = fixed priority, 1 = round robin.
   logic [2:0] m_pend [2];
   logic       m_busy [2];
   logic [1:0] m_ptr  [2];
   logic       m_err  [2];
   logic [1:0] m_sel  [2];
   logic [8:0] m_out  [2];

   task automatic model_update(input int md, input logic r, input logic [2:0] d, input logic f);
      logic [2:0] req;
      logic [2:0] fr;
      logic       g;
      int         w;
      int         idx;
      if (r) begin
         m_pend[md] = '0; m_busy[md] = 1'b0; m_ptr[md] = '0;
         m_err[md]  = 1'b0; m_sel[md] = '0; m_out[md] = '0;
         return;
      end
      req = m_pend[md] | d;
      w   = -1;
      for (int i = 0; i < 3; i++) begin
         idx = ((md == 1) ? int'(m_ptr[md]) : 0) + i;
         idx = idx % 3;
         if (w < 0 && req[idx[1:0]]) w = idx;
      end
      g = !m_busy[md] && (w >= 0);
      if (!m_busy[md] && f) m_err[md] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         logic held, won;
         held = m_pend[md][k];
         won  = g && (w == k);
         if (d[k] && held && !won) m_err[md] = 1'b1;
         m_pend[md][k] = won ? (held && d[k]) : (held || d[k]);
      end
      m_busy[md] = m_busy[md] ? !f : g;
      fr = g ? (3'b001 << w) : 3'b000;
      if (g) begin
         m_sel[md] = 2'(w);
         if (md == 1) m_ptr[md] = 2'((w + 1) % 3);
      end
      m_out[md] = {g, g, fr, m_sel[md], m_busy[md], m_err[md]};
   endtask

   task automatic step(input logic r, input logic [2:0] d, input logic f);
      rst = r;
      {i_drive2, i_drive1, i_drive0} = d;
      i_freeNext = f;
      @(posedge clk);
      #1;
      model_update(0, r, d, f);
      model_update(1, r, d, f);
      check("model_fx", 32'(out_fx), 32'(m_out[0]));
      check("model_rr", 32'(out_rr), 32'(m_out[1]));
   endtask

   typedef struct {
      logic       r;
      logic [2:0] d;
      logic       f;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl [38];

   function automatic logic [8:0] e(input logic dn, input logic [2:0] fr, input logic [1:0] s,
                                    input logic b, input logic er);
      return {dn, dn, fr, s, b, er};
   endfunction

   function automatic vec_t v(input logic r, input logic [2:0] d, input logic f, input logic [8:0] x);
      vec_t t;
      t.r = r; t.d = d; t.f = f; t.exp = x;
      return t;
   endfunction

   int cnt_fx0, cnt_fx2, cnt_rr0, cnt_rr2;

   initial begin
      rst = 1'b1; i_drive0 = 1'b0; i_drive1 = 1'b0; i_drive2 = 1'b0; i_freeNext = 1'b0;

      // Expected outputs of the round-robin instance after each edge.
      tbl[0]  = v(1'b1, 3'b000, 1'b0, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
      tbl[1]  = v(1'b0, 3'b010, 1'b0, e(1'b1, 3'b010, 2'd1, 1'b1, 1'b0));
      tbl[2]  = v(1'b0, 3'b000, 1'b0, e(1'b0, 3'b000, 2'd1, 1'b1, 1'b0));
      tbl[3]  = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd1, 1'b0, 1'b0));
      tbl[4]  = v(1'b0, 3'b000, 1'b0, e(1'b0, 3'b000, 2'd1, 1'b0, 1'b0));
      tbl[5]  = v(1'b1, 3'b000, 1'b0, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
      tbl[6]  = v(1'b0, 3'b111, 1'b0, e(1'b1, 3'b001, 2'd0, 1'b1, 1'b0));
      tbl[7]  = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
      tbl[8]  = v(1'b0, 3'b000, 1'b0, e(1'b1, 3'b010, 2'd1, 1'b1, 1'b0));
      tbl[9]  = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd1, 1'b0, 1'b0));
      tbl[10] = v(1'b0, 3'b000, 1'b0, e(1'b1, 3'b100, 2'd2, 1'b1, 1'b0));
      tbl[11] = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd2, 1'b0, 1'b0));
      tbl[12] = v(1'b0, 3'b111, 1'b0, e(1'b1, 3'b001, 2'd0, 1'b1, 1'b0));
      tbl[13] = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
      tbl[14] = v(1'b0, 3'b000, 1'b0, e(1'b1, 3'b010, 2'd1, 1'b1, 1'b0));
      tbl[15] = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd1, 1'b0, 1'b0));
      tbl[16] = v(1'b0, 3'b000, 1'b0, e(1'b1, 3'b100, 2'd2, 1'b1, 1'b0));
      tbl[17] = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd2, 1'b0, 1'b0));
      tbl[18] = v(1'b0, 3'b001, 1'b0, e(1'b1, 3'b001, 2'd0, 1'b1, 1'b0));
      tbl[19] = v(1'b0, 3'b100, 1'b0, e(1'b0, 3'b000, 2'd0, 1'b1, 1'b0));
      tbl[20] = v(1'b0, 3'b100, 1'b0, e(1'b0, 3'b000, 2'd0, 1'b1, 1'b1));
      tbl[21] = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b1));
      tbl[22] = v(1'b0, 3'b000, 1'b0, e(1'b1, 3'b100, 2'd2, 1'b1, 1'b1));
      tbl[23] = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd2, 1'b0, 1'b1));
      tbl[24] = v(1'b0, 3'b000, 1'b0, e(1'b0, 3'b000, 2'd2, 1'b0, 1'b1));
      tbl[25] = v(1'b1, 3'b000, 1'b0, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
      tbl[26] = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b1));
      tbl[27] = v(1'b1, 3'b000, 1'b0, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
      tbl[28] = v(1'b0, 3'b001, 1'b0, e(1'b1, 3'b001, 2'd0, 1'b1, 1'b0));
      tbl[29] = v(1'b0, 3'b001, 1'b1, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
      tbl[30] = v(1'b0, 3'b000, 1'b0, e(1'b1, 3'b001, 2'd0, 1'b1, 1'b0));
      tbl[31] = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
      tbl[32] = v(1'b0, 3'b001, 1'b0, e(1'b1, 3'b001, 2'd0, 1'b1, 1'b0));
      tbl[33] = v(1'b0, 3'b110, 1'b0, e(1'b0, 3'b000, 2'd0, 1'b1, 1'b0));
      tbl[34] = v(1'b1, 3'b000, 1'b0, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
      tbl[35] = v(1'b0, 3'b000, 1'b0, e(1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
      tbl[36] = v(1'b0, 3'b100, 1'b0, e(1'b1, 3'b100, 2'd2, 1'b1, 1'b0));
      tbl[37] = v(1'b0, 3'b000, 1'b1, e(1'b0, 3'b000, 2'd2, 1'b0, 1'b0));

      @(negedge clk);
      for (int i = 0; i < 38; i++) begin
         step(tbl[i].r, tbl[i].d, tbl[i].f);
         check($sformatf("vec%0d", i), 32'(out_rr), 32'(tbl[i].exp));
      end

      // Continuous requests on 0 and 2: fixed priority starves 2, round robin alternates.
      step(1'b1, 3'b000, 1'b0);
      cnt_fx0 = 0; cnt_fx2 = 0; cnt_rr0 = 0; cnt_rr2 = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 3'b101, (k % 2) == 1);
         cnt_fx0 += int'(fx_free0); cnt_fx2 += int'(fx_free2);
         cnt_rr0 += int'(rr_free0); cnt_rr2 += int'(rr_free2);
      end
      check("starve_fx_g0", 32'(cnt_fx0), 32'd10);
      check("starve_fx_g2", 32'(cnt_fx2), 32'd0);
      check("starve_rr_g0", 32'(cnt_rr0), 32'd5);
      check("starve_rr_g2", 32'(cnt_rr2), 32'd5);

      // Randomized traffic against the model.
      step(1'b1, 3'b000, 1'b0);
      for (int n = 0; n < 3000; n++) begin
         logic       r;
         logic [2:0] d;
         logic       f;
         r = ($urandom_range(0, 127) == 0);
         d = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
         f = ($urandom_range(0, 2) == 0);
         step(r, d, f);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
